noc_endpoint: RTL and testbench
===============================

// Module: noc_endpoint
// PURPOSE
// Network interface for one tile of the 4x4 mesh. It attaches to a router's local port.
// Core-side TX requests are packed into flits and queued, then injected into the router.
// Flits ejected by the router are checked, queued and delivered to the core.
// Self-addressed requests loop back locally and never enter the mesh.
// PARAMETERS
// XCOORD     0   this tile's column (0..3); stamped as src_x, compared against dest_x
// YCOORD     0   this tile's row (0..3); stamped as src_y, compared against dest_y
// PAYLOAD_W  16  payload bits per flit
// TXQ_DEPTH  4   TX queue entries; power of 2, >=2
// RXQ_DEPTH  4   RX queue entries; power of 2, >=2
// PORTS
// clk              in   1      clock; single clock domain
// rst_n            in   1      asynchronous active-low reset
// core_tx_valid    in   1      core has a request
// core_tx_ready    out  1      TX queue can accept
// core_tx_dest_x   in   2      destination column
// core_tx_dest_y   in   2      destination row
// core_tx_payload  in   PAYLOAD_W  request data
// inj_valid        out  1      flit toward router local input
// inj_ready        in   1      router accepts flit
// inj_flit         out  FLIT_W flit toward router (noc_pkg::flit_t)
// ej_valid         in   1      router presents ejected flit
// ej_ready         out  1      endpoint accepts flit
// ej_flit          in   FLIT_W flit from router
// core_rx_valid    out  1      delivered packet available
// core_rx_ready    in   1      core consumes packet
// core_rx_src_x    out  2      sender column
// core_rx_src_y    out  2      sender row
// core_rx_payload  out  PAYLOAD_W  delivered data
// tx_cnt / rx_cnt / misroute_cnt  out  16 each  injected / delivered-to-RXQ / dropped flits
// BEHAVIOUR
// - Transfer on any channel = valid&&ready at posedge clk.
// - A valid signal never drops before its transfer.
// - Flit data is held stable while valid && !ready.
// - Reset (async, any time): queues flushed; all valid outputs 0; counters 0.
//   Any in-flight flit is lost. core_tx_ready and ej_ready rise on the first edge after rst_n=1.
// - Packing: flit = {dest_x,dest_y,src_x=XCOORD,src_y=YCOORD,payload}; FLIT_W = 8+PAYLOAD_W.
// - core_tx_ready = !txq_full. No fall-through: a push at edge N gives inj_valid=1 from cycle N+1.
// - TXQ head drives inj_flit. inj_valid = !txq_empty && head not self-addressed.
// - Self-addressed head (dest==own) goes to RXQ via loopback, not to inj.
//   Loopback transfers when RXQ has space and no ej transfer happens that cycle; it costs 1 cycle.
// - ej_ready = !rxq_full. Ejection has priority over loopback: one RXQ push per cycle.
// - An accepted ej flit with dest != (XCOORD,YCOORD) is dropped, not pushed.
//   It increments misroute_cnt and does not increment rx_cnt.
// - Simultaneous push+pop on either queue: occupancy unchanged.
//   Push on full is impossible (ready low). Pop on empty is impossible (valid low).
// - Pointers are log2(DEPTH)+1 bits. full/empty come from the MSB compare; index wraps modulo DEPTH.
// - All counters saturate at 16'hFFFF. tx_cnt counts inj transfers only.
//   rx_cnt counts RXQ pushes (ejection + loopback).
// - Ordering: FIFO per direction. Loopback and injected requests leave the TXQ in issue order.
// STRUCTURE
// - noc_pkg: COORD_W=2, flit_t packed struct {dest_x,dest_y,src_x,src_y,payload}, MESH_DIM=4.
// - Sub-module noc_fifo #(WIDTH,DEPTH): sync FIFO with push/pop/full/empty and async reset.
//   Instantiated twice (TXQ, RXQ).
// - Top-level logic: packing/unpacking, address compare, RXQ push mux, saturating counters.
// TESTING
// 1 Reset: rst_n=0 mid-traffic with 3 flits queued -> all valids 0 the same cycle, counters 0,
//   queues empty after release.
// 2 Inject: tile (1,2), request dest (3,0) payload 16'hBEEF -> next cycle inj_flit
//   = {3,0,1,2,BEEF}, inj_valid=1; tx_cnt=1 after the transfer.
// 3 Backpressure: inj_ready=0, 5 requests with DEPTH=4 -> core_tx_ready=0 after 4 accepts;
//   raise inj_ready -> 5 flits injected in order.
// 4 Eject: ej flit dest (1,2), src (0,3), payload 16'h1234 -> core_rx_* = 0,3,1234,
//   core_rx_valid=1 the next cycle. Misaddressed dest (2,2) -> dropped, misroute_cnt=1.
// 5 Loopback race: self-addressed request and ej flit both ready with RXQ at 3/4
//   -> ej flit pushed first, loopback the next cycle after a core pop.
// 6 Saturation: force 65537 misrouted flits -> misroute_cnt holds 16'hFFFF.

Source files
------------

// File: rtl/noc_pkg.sv
// Shared definitions for the mesh network interface.
// Contents:
//   COORD_W, MESH_DIM  coordinate width and mesh size (4x4)
//   flit_t             flit layout {dest_x, dest_y, src_x, src_y, payload}
//                      shown here for the default 16-bit payload
//   coord_match        tile-address comparison
//   sat_inc            16-bit increment that holds at 16'hFFFF
package noc_pkg;

  localparam int COORD_W       = 2;
  localparam int MESH_DIM      = 4;
  localparam int PAYLOAD_W_DEF = 16;

  typedef struct packed {
    logic [COORD_W-1:0]       dest_x;
    logic [COORD_W-1:0]       dest_y;
    logic [COORD_W-1:0]       src_x;
    logic [COORD_W-1:0]       src_y;
    logic [PAYLOAD_W_DEF-1:0] payload;
  } flit_t;

  function automatic logic coord_match(input logic [COORD_W-1:0] ax,
                                       input logic [COORD_W-1:0] ay,
                                       input logic [COORD_W-1:0] bx,
                                       input logic [COORD_W-1:0] by);
    return (ax == bx) && (ay == by);
  endfunction

  function automatic logic [15:0] sat_inc(input logic [15:0] value);
    return (value == 16'hFFFF) ? value : value + 16'd1;
  endfunction

endpackage

// File: rtl/noc_endpoint_if.sv
// Bundle of the endpoint's three handshake channels plus the core RX channel.
// Channels:
//   core_tx_*  core -> endpoint requests (dest, payload)
//   inj_*      endpoint -> router local input (full flit)
//   ej_*       router -> endpoint ejected flits (full flit)
//   core_rx_*  endpoint -> core delivered packets (src, payload)
// Modports:
//   slave   the endpoint's view
//   master  the surrounding core/router view
interface noc_endpoint_if #(parameter int PAYLOAD_W = 16);
  import noc_pkg::*;

  localparam int FLIT_W = 4*COORD_W + PAYLOAD_W;

  logic                 core_tx_valid;
  logic                 core_tx_ready;
  logic [COORD_W-1:0]   core_tx_dest_x;
  logic [COORD_W-1:0]   core_tx_dest_y;
  logic [PAYLOAD_W-1:0] core_tx_payload;

  logic                 inj_valid;
  logic                 inj_ready;
  logic [FLIT_W-1:0]    inj_flit;

  logic                 ej_valid;
  logic                 ej_ready;
  logic [FLIT_W-1:0]    ej_flit;

  logic                 core_rx_valid;
  logic                 core_rx_ready;
  logic [COORD_W-1:0]   core_rx_src_x;
  logic [COORD_W-1:0]   core_rx_src_y;
  logic [PAYLOAD_W-1:0] core_rx_payload;

  modport slave (
    input  core_tx_valid, core_tx_dest_x, core_tx_dest_y, core_tx_payload,
    input  inj_ready, ej_valid, ej_flit, core_rx_ready,
    output core_tx_ready, inj_valid, inj_flit, ej_ready,
    output core_rx_valid, core_rx_src_x, core_rx_src_y, core_rx_payload
  );

  modport master (
    output core_tx_valid, core_tx_dest_x, core_tx_dest_y, core_tx_payload,
    output inj_ready, ej_valid, ej_flit, core_rx_ready,
    input  core_tx_ready, inj_valid, inj_flit, ej_ready,
    input  core_rx_valid, core_rx_src_x, core_rx_src_y, core_rx_payload
  );

endinterface

// File: rtl/noc_fifo.sv
// Synchronous FIFO without fall-through: a word pushed at edge N is visible
// on dout from cycle N+1.
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset (flushes the queue)
//   push, din    write request and data (ignored while full)
//   pop          read request (ignored while empty)
//   dout         head entry
//   full, empty  occupancy status
// Pointers carry one extra wrap bit so full and empty are distinguished by
// comparing that MSB; the lower bits index the storage modulo DEPTH.
module noc_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr_r;
  logic [AW:0]      rd_ptr_r;
  logic [WIDTH-1:0] mem_r [DEPTH];
  logic             push_s;
  logic             pop_s;

  assign full   = (wr_ptr_r[AW] != rd_ptr_r[AW]) &&
                  (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
  assign empty  = (wr_ptr_r == rd_ptr_r);
  assign push_s = push && !full;
  assign pop_s  = pop && !empty;
  assign dout   = mem_r[rd_ptr_r[AW-1:0]];

  // Read/write pointer advance; reset empties the queue.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r <= {(AW+1){1'b0}};
      rd_ptr_r <= {(AW+1){1'b0}};
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + {{AW{1'b0}}, 1'b1};
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + {{AW{1'b0}}, 1'b1};
      end
    end
  end

  // Storage write; contents need no reset because the pointers gate them.
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_r[wr_ptr_r[AW-1:0]] <= din;
    end
  end

endmodule

// File: rtl/noc_endpoint.sv
// Network interface for one tile of the 4x4 mesh, attached to a router's
// local port.
// Ports:
//   clk, rst_n     clock, asynchronous active-low reset
//   bus (slave)    core TX, router injection, router ejection, core RX
//   tx_cnt         saturating count of flits injected into the router
//   rx_cnt         saturating count of RX queue pushes (ejection + loopback)
//   misroute_cnt   saturating count of ejected flits dropped as misaddressed
// Core requests are packed with this tile's coordinates and queued in the
// TX queue. A non-self-addressed head is offered to the router; a
// self-addressed head loops back into the RX queue instead. Ejected flits
// addressed here go into the RX queue; others are dropped and counted.
module noc_endpoint
  import noc_pkg::*;
#(
  parameter int XCOORD    = 0,
  parameter int YCOORD    = 0,
  parameter int PAYLOAD_W = 16,
  parameter int TXQ_DEPTH = 4,
  parameter int RXQ_DEPTH = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  noc_endpoint_if.slave bus,
  output logic [15:0]   tx_cnt,
  output logic [15:0]   rx_cnt,
  output logic [15:0]   misroute_cnt
);

  localparam int FLIT_W  = 4*COORD_W + PAYLOAD_W;
  // The RX queue keeps only what the core sees: {src_x, src_y, payload}.
  localparam int RXQ_W   = 2*COORD_W + PAYLOAD_W;
  localparam int SY_LSB  = PAYLOAD_W;
  localparam int SX_LSB  = PAYLOAD_W + COORD_W;
  localparam int DY_LSB  = PAYLOAD_W + 2*COORD_W;
  localparam int DX_LSB  = PAYLOAD_W + 3*COORD_W;
  localparam logic [COORD_W-1:0] OWN_X = COORD_W'(XCOORD);
  localparam logic [COORD_W-1:0] OWN_Y = COORD_W'(YCOORD);

  logic [FLIT_W-1:0] tx_flit_s;
  logic [FLIT_W-1:0] txq_head_s;
  logic              txq_full_s;
  logic              txq_empty_s;
  logic              txq_pop_s;
  logic [RXQ_W-1:0]  rxq_din_s;
  logic [RXQ_W-1:0]  rxq_head_s;
  logic              rxq_full_s;
  logic              rxq_empty_s;
  logic              rxq_push_s;

  logic              rdy_en_r;
  logic              tx_ready_s;
  logic              ej_ready_s;
  logic              inj_valid_s;
  logic              head_self_s;
  logic              ej_self_s;
  logic              tx_push_s;
  logic              inj_xfer_s;
  logic              ej_xfer_s;
  logic              lb_xfer_s;

  logic [15:0]       tx_cnt_r;
  logic [15:0]       rx_cnt_r;
  logic [15:0]       mis_cnt_r;

  // Request packing: destination first, this tile as source, then data.
  assign tx_flit_s = {bus.core_tx_dest_x, bus.core_tx_dest_y, OWN_X, OWN_Y,
                      bus.core_tx_payload};

  assign head_self_s = coord_match(txq_head_s[DX_LSB +: COORD_W],
                                   txq_head_s[DY_LSB +: COORD_W],
                                   OWN_X, OWN_Y);
  assign ej_self_s   = coord_match(bus.ej_flit[DX_LSB +: COORD_W],
                                   bus.ej_flit[DY_LSB +: COORD_W],
                                   OWN_X, OWN_Y);

  // Readies stay low through reset and rise on the first edge after release.
  assign tx_ready_s  = rdy_en_r && !txq_full_s;
  assign ej_ready_s  = rdy_en_r && !rxq_full_s;
  assign inj_valid_s = !txq_empty_s && !head_self_s;

  assign tx_push_s   = bus.core_tx_valid && tx_ready_s;
  assign inj_xfer_s  = inj_valid_s && bus.inj_ready;
  assign ej_xfer_s   = bus.ej_valid && ej_ready_s;
  // Ejection owns the single RX push slot; loopback waits for a free cycle.
  assign lb_xfer_s   = !txq_empty_s && head_self_s && !rxq_full_s && !ej_xfer_s;

  assign txq_pop_s   = inj_xfer_s || lb_xfer_s;
  assign rxq_push_s  = (ej_xfer_s && ej_self_s) || lb_xfer_s;

  // RX queue write-data select: ejected flit when one is accepted, else loopback head.
  always_comb begin
    rxq_din_s = txq_head_s[RXQ_W-1:0];
    if (ej_xfer_s) begin
      rxq_din_s = bus.ej_flit[RXQ_W-1:0];
    end else begin
      rxq_din_s = txq_head_s[RXQ_W-1:0];
    end
  end

  noc_fifo #(.WIDTH(FLIT_W), .DEPTH(TXQ_DEPTH)) u_txq (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (tx_push_s),
    .din   (tx_flit_s),
    .pop   (txq_pop_s),
    .dout  (txq_head_s),
    .full  (txq_full_s),
    .empty (txq_empty_s)
  );

  noc_fifo #(.WIDTH(RXQ_W), .DEPTH(RXQ_DEPTH)) u_rxq (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (rxq_push_s),
    .din   (rxq_din_s),
    .pop   (bus.core_rx_valid && bus.core_rx_ready),
    .dout  (rxq_head_s),
    .full  (rxq_full_s),
    .empty (rxq_empty_s)
  );

  // Ready-enable flag: holds both readies low until the first edge out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdy_en_r <= 1'b0;
    end else begin
      rdy_en_r <= 1'b1;
    end
  end

  // Saturating activity counters for injected, delivered and dropped flits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_cnt_r  <= 16'h0000;
      rx_cnt_r  <= 16'h0000;
      mis_cnt_r <= 16'h0000;
    end else begin
      if (inj_xfer_s) begin
        tx_cnt_r <= sat_inc(tx_cnt_r);
      end
      if (rxq_push_s) begin
        rx_cnt_r <= sat_inc(rx_cnt_r);
      end
      if (ej_xfer_s && !ej_self_s) begin
        mis_cnt_r <= sat_inc(mis_cnt_r);
      end
    end
  end

  assign bus.core_tx_ready   = tx_ready_s;
  assign bus.inj_valid       = inj_valid_s;
  assign bus.inj_flit        = txq_head_s;
  assign bus.ej_ready        = ej_ready_s;
  assign bus.core_rx_valid   = !rxq_empty_s;
  assign bus.core_rx_src_x   = rxq_head_s[SX_LSB +: COORD_W];
  assign bus.core_rx_src_y   = rxq_head_s[SY_LSB +: COORD_W];
  assign bus.core_rx_payload = rxq_head_s[PAYLOAD_W-1:0];

  assign tx_cnt       = tx_cnt_r;
  assign rx_cnt       = rx_cnt_r;
  assign misroute_cnt = mis_cnt_r;

endmodule

// File: tb/tb_noc_endpoint.sv
// Self-checking bench for noc_endpoint at tile (1,2). A queue-based
// reference model predicts every output each cycle; directed sequences
// cover injection, backpressure, ejection, misroute, loopback race, reset
// and counter saturation, followed by randomized traffic.
module tb_noc_endpoint;
  import noc_pkg::*;

  localparam int XC    = 1;
  localparam int YC    = 2;
  localparam int PW    = 16;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] tx_cnt;
  logic [15:0] rx_cnt;
  logic [15:0] misroute_cnt;

  noc_endpoint_if #(.PAYLOAD_W(PW)) bus ();

  noc_endpoint #(
    .XCOORD(XC), .YCOORD(YC), .PAYLOAD_W(PW), .TXQ_DEPTH(DEPTH), .RXQ_DEPTH(DEPTH)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .bus          (bus),
    .tx_cnt       (tx_cnt),
    .rx_cnt       (rx_cnt),
    .misroute_cnt (misroute_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [23:0] txq_m[$];
  logic [23:0] rxq_m[$];
  logic        rdy_en_m;
  logic [15:0] tx_cnt_m, rx_cnt_m, mis_cnt_m;
  logic        tx_x_last, ej_x_last;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 'h%0h, want 'h%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [23:0] mk_flit(input logic [1:0] dx, input logic [1:0] dy,
                                          input logic [1:0] sx, input logic [1:0] sy,
                                          input logic [15:0] pl);
    flit_t f;
    f.dest_x = dx; f.dest_y = dy; f.src_x = sx; f.src_y = sy; f.payload = pl;
    return f;
  endfunction

  function automatic logic is_own(input logic [23:0] fl);
    flit_t f;
    f = fl;
    return (f.dest_x == 2'(XC)) && (f.dest_y == 2'(YC));
  endfunction

  function automatic logic [15:0] bump(input logic [15:0] v);
    return (v == 16'hFFFF) ? 16'hFFFF : v + 16'd1;
  endfunction

  task automatic compare_outputs();
    logic  head_self;
    logic  exp_inj_v;
    flit_t rf;
    head_self = (txq_m.size() > 0) ? is_own(txq_m[0]) : 1'b0;
    exp_inj_v = (txq_m.size() > 0) && !head_self;
    check_eq("core_tx_ready", bus.core_tx_ready, rdy_en_m && (txq_m.size() < DEPTH));
    check_eq("ej_ready", bus.ej_ready, rdy_en_m && (rxq_m.size() < DEPTH));
    check_eq("inj_valid", bus.inj_valid, exp_inj_v);
    if (exp_inj_v) check_eq("inj_flit", bus.inj_flit, txq_m[0]);
    check_eq("core_rx_valid", bus.core_rx_valid, rxq_m.size() > 0);
    if (rxq_m.size() > 0) begin
      rf = rxq_m[0];
      check_eq("core_rx_src_x", bus.core_rx_src_x, rf.src_x);
      check_eq("core_rx_src_y", bus.core_rx_src_y, rf.src_y);
      check_eq("core_rx_payload", bus.core_rx_payload, rf.payload);
    end
    check_eq("tx_cnt", tx_cnt, tx_cnt_m);
    check_eq("rx_cnt", rx_cnt, rx_cnt_m);
    check_eq("misroute_cnt", misroute_cnt, mis_cnt_m);
  endtask

  // Advance the model by one clock edge using the inputs held during the cycle.
  task automatic update_model();
    int          txs, rxs;
    logic        hs, tx_x, ej_x, ej_ok, inj_x, lb_x, pop_rx;
    logic [23:0] head;
    txs    = txq_m.size();
    rxs    = rxq_m.size();
    head   = (txs > 0) ? txq_m[0] : 24'h000000;
    hs     = (txs > 0) && is_own(head);
    tx_x   = bus.core_tx_valid && rdy_en_m && (txs < DEPTH);
    ej_x   = bus.ej_valid && rdy_en_m && (rxs < DEPTH);
    ej_ok  = ej_x && is_own(bus.ej_flit);
    inj_x  = (txs > 0) && !hs && bus.inj_ready;
    lb_x   = hs && (rxs < DEPTH) && !ej_x;
    pop_rx = (rxs > 0) && bus.core_rx_ready;
    if (pop_rx) void'(rxq_m.pop_front());
    if (inj_x || lb_x) void'(txq_m.pop_front());
    if (ej_ok) rxq_m.push_back(bus.ej_flit);
    else if (lb_x) rxq_m.push_back(head);
    if (tx_x) txq_m.push_back(mk_flit(bus.core_tx_dest_x, bus.core_tx_dest_y,
                                      2'(XC), 2'(YC), bus.core_tx_payload));
    if (inj_x) tx_cnt_m = bump(tx_cnt_m);
    if (ej_ok || lb_x) rx_cnt_m = bump(rx_cnt_m);
    if (ej_x && !ej_ok) mis_cnt_m = bump(mis_cnt_m);
    rdy_en_m  = 1'b1;
    tx_x_last = tx_x;
    ej_x_last = ej_x;
  endtask

  // Called at a negedge with inputs set; returns at the next negedge.
  task automatic step();
    #1;
    compare_outputs();
    @(posedge clk);
    update_model();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    bus.core_tx_valid = 1'b0; bus.core_tx_dest_x = 2'd0; bus.core_tx_dest_y = 2'd0;
    bus.core_tx_payload = 16'h0000;
    bus.inj_ready = 1'b0; bus.ej_valid = 1'b0; bus.ej_flit = 24'h000000;
    bus.core_rx_ready = 1'b0;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    #1;
    check_eq("rst_inj_valid", bus.inj_valid, 1'b0);
    check_eq("rst_core_rx_valid", bus.core_rx_valid, 1'b0);
    check_eq("rst_core_tx_ready", bus.core_tx_ready, 1'b0);
    check_eq("rst_ej_ready", bus.ej_ready, 1'b0);
    check_eq("rst_tx_cnt", tx_cnt, 16'h0000);
    check_eq("rst_rx_cnt", rx_cnt, 16'h0000);
    check_eq("rst_misroute_cnt", misroute_cnt, 16'h0000);
    txq_m.delete(); rxq_m.delete();
    rdy_en_m = 1'b0; tx_cnt_m = 16'h0000; rx_cnt_m = 16'h0000; mis_cnt_m = 16'h0000;
    tx_x_last = 1'b0; ej_x_last = 1'b0;
    idle_inputs();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic drive_random(input int self_pct, input int mis_pct,
                              input int inj_pct, input int rx_pct);
    logic [1:0] dx, dy;
    if (!(bus.core_tx_valid && !tx_x_last)) begin
      bus.core_tx_valid = ($urandom_range(0, 99) < 60);
      if ($urandom_range(0, 99) < self_pct) begin
        dx = 2'(XC); dy = 2'(YC);
      end else begin
        dx = 2'($urandom_range(0, 3)); dy = 2'($urandom_range(0, 3));
      end
      bus.core_tx_dest_x = dx; bus.core_tx_dest_y = dy;
      bus.core_tx_payload = 16'($urandom);
    end
    if (!(bus.ej_valid && !ej_x_last)) begin
      bus.ej_valid = ($urandom_range(0, 99) < 50);
      if ($urandom_range(0, 99) < mis_pct) begin
        dx = 2'($urandom_range(0, 3)); dy = 2'($urandom_range(0, 3));
        if (dx == 2'(XC) && dy == 2'(YC)) dx = dx ^ 2'd1;
      end else begin
        dx = 2'(XC); dy = 2'(YC);
      end
      bus.ej_flit = mk_flit(dx, dy, 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
                            16'($urandom));
    end
    bus.inj_ready     = ($urandom_range(0, 99) < inj_pct);
    bus.core_rx_ready = ($urandom_range(0, 99) < rx_pct);
  endtask

  logic [15:0] got_q[$];

  initial begin
    idle_inputs();
    @(negedge clk);
    apply_reset();

    // Inject: request to (3,0) from tile (1,2)
    bus.core_tx_valid = 1'b1; bus.core_tx_dest_x = 2'd3; bus.core_tx_dest_y = 2'd0;
    bus.core_tx_payload = 16'hBEEF;
    step();                      // ready still low on the first cycle out of reset
    step();                      // accepted here
    bus.core_tx_valid = 1'b0;
    check_eq("inj_valid_next", bus.inj_valid, 1'b1);
    check_eq("inj_flit_beef", bus.inj_flit, 24'hC6BEEF);
    bus.inj_ready = 1'b1;
    step();
    bus.inj_ready = 1'b0;
    check_eq("tx_cnt_one", tx_cnt, 16'd1);

    // Backpressure: 4 accepted, fifth stalls until the router is ready
    for (int i = 0; i < 4; i++) begin
      bus.core_tx_valid = 1'b1; bus.core_tx_dest_x = 2'd0; bus.core_tx_dest_y = 2'd0;
      bus.core_tx_payload = 16'h5A00 + 16'(i);
      step();
    end
    check_eq("bp_tx_ready_low", bus.core_tx_ready, 1'b0);
    bus.core_tx_payload = 16'h5A04;
    step();
    bus.inj_ready = 1'b1;
    got_q.delete();
    for (int c = 0; c < 12; c++) begin
      if (tx_x_last) bus.core_tx_valid = 1'b0;
      if (bus.inj_valid) got_q.push_back(bus.inj_flit[15:0]);
      step();
    end
    bus.inj_ready = 1'b0;
    check_eq("bp_inj_count", got_q.size(), 5);
    for (int i = 0; i < 5 && i < got_q.size(); i++)
      check_eq("bp_inj_order", got_q[i], 16'h5A00 + 16'(i));
    check_eq("bp_tx_cnt", tx_cnt, 16'd6);

    // Eject: addressed here, then misaddressed
    apply_reset();
    step();
    bus.ej_valid = 1'b1; bus.ej_flit = mk_flit(2'd1, 2'd2, 2'd0, 2'd3, 16'h1234);
    step();
    bus.ej_valid = 1'b0;
    check_eq("ej_rx_valid", bus.core_rx_valid, 1'b1);
    check_eq("ej_rx_src_x", bus.core_rx_src_x, 2'd0);
    check_eq("ej_rx_src_y", bus.core_rx_src_y, 2'd3);
    check_eq("ej_rx_payload", bus.core_rx_payload, 16'h1234);
    bus.ej_valid = 1'b1; bus.ej_flit = mk_flit(2'd2, 2'd2, 2'd0, 2'd3, 16'h9999);
    step();
    bus.ej_valid = 1'b0;
    step();
    check_eq("misroute_one", misroute_cnt, 16'd1);
    check_eq("misroute_rx_cnt", rx_cnt, 16'd1);
    bus.core_rx_ready = 1'b1;
    step();
    bus.core_rx_ready = 1'b0;

    // Loopback race with the RX queue at 3/4
    for (int i = 0; i < 3; i++) begin
      bus.ej_valid = 1'b1; bus.ej_flit = mk_flit(2'd1, 2'd2, 2'd3, 2'd3, 16'h3000 + 16'(i));
      step();
    end
    bus.ej_valid = 1'b0;
    bus.core_tx_valid = 1'b1; bus.core_tx_dest_x = 2'd1; bus.core_tx_dest_y = 2'd2;
    bus.core_tx_payload = 16'hAAAA;
    step();
    bus.core_tx_valid = 1'b0;
    check_eq("race_self_not_injected", bus.inj_valid, 1'b0);
    bus.ej_valid = 1'b1; bus.ej_flit = mk_flit(2'd1, 2'd2, 2'd2, 2'd0, 16'hBBBB);
    step();
    bus.ej_valid = 1'b0;
    check_eq("race_rxq_full", bus.ej_ready, 1'b0);
    bus.core_rx_ready = 1'b1;
    step();
    bus.core_rx_ready = 1'b0;
    step();
    got_q.delete();
    bus.core_rx_ready = 1'b1;
    for (int c = 0; c < 6; c++) begin
      if (bus.core_rx_valid) got_q.push_back(bus.core_rx_payload);
      step();
    end
    bus.core_rx_ready = 1'b0;
    check_eq("race_rx_count", got_q.size(), 4);
    if (got_q.size() == 4) begin
      check_eq("race_order0", got_q[0], 16'h3001);
      check_eq("race_order1", got_q[1], 16'h3002);
      check_eq("race_ej_before_lb", got_q[2], 16'hBBBB);
      check_eq("race_lb_last", got_q[3], 16'hAAAA);
    end
    check_eq("race_rx_cnt", rx_cnt, 16'd6);

    // Randomized traffic in phases of varying pressure
    apply_reset();
    for (int p = 0; p < 4; p++) begin
      for (int c = 0; c < 800; c++) begin
        case (p)
          0: drive_random(25, 20, 80, 80);
          1: drive_random(40, 10, 20, 20);
          2: drive_random(10, 50, 90, 30);
          default: drive_random(60, 30, 50, 90);
        endcase
        step();
      end
    end

    // Reset mid-traffic with 3 flits queued
    idle_inputs();
    bus.inj_ready = 1'b1; bus.core_rx_ready = 1'b1;
    repeat (12) step();
    bus.inj_ready = 1'b0; bus.core_rx_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      bus.core_tx_valid = 1'b1; bus.core_tx_dest_x = 2'd0; bus.core_tx_dest_y = 2'd1;
      bus.core_tx_payload = 16'h7700 + 16'(i);
      step();
    end
    bus.core_tx_valid = 1'b0;
    check_eq("pre_rst_inj_valid", bus.inj_valid, 1'b1);
    apply_reset();
    bus.inj_ready = 1'b1;
    step();
    step();
    check_eq("post_rst_inj_valid", bus.inj_valid, 1'b0);
    check_eq("post_rst_rx_valid", bus.core_rx_valid, 1'b0);
    bus.inj_ready = 1'b0;

    // Saturation: 65537 misrouted flits
    apply_reset();
    step();
    bus.ej_valid = 1'b1; bus.ej_flit = mk_flit(2'd3, 2'd3, 2'd0, 2'd0, 16'hDEAD);
    for (int n = 0; n < 65537; n++) step();
    bus.ej_valid = 1'b0;
    step();
    check_eq("sat_misroute", misroute_cnt, 16'hFFFF);
    check_eq("sat_rx_cnt", rx_cnt, 16'h0000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
